stream_demux_1to2: RTL

Registered 1-to-2 stream demultiplexer with packet lock: routes a valid/ready stream of framed packets to one of two output streams chosen by `Select_Line`. Receive-side counterpart of the 2:1 multiplexer; it splits a merged stream back into two channels. The route is sampled on a packet's first beat and held until its `Last` beat, so packets are never split across outputs. Each output has a one-entry register stage, and a per-output packet counter is provided for debug.

---
 rtl/stream_demux_1to2.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/stream_demux_1to2.sv
// Purpose : 1-to-2 valid/ready stream demux; route sampled on a packet's first beat, held to its Last beat.
// Latency : 1 cycle from input acceptance to the selected output register.
// Backpr. : In_Ready = !OutR_Valid || OutR_Ready for the effective route R only; idle output drains independently.
//
// Ports:
//   Clock, Reset_n                 - rising-edge clock, synchronous active-low reset
//   In_Data/In_Valid/In_Last       - upstream beat; In_Ready back to upstream
//   Select_Line                    - route for a new packet (0 -> Out0, 1 -> Out1)
//   OutX_Data/OutX_Valid/OutX_Last - registered downstream beat; OutX_Ready from downstream
//   Mid_Packet, Locked_Sel         - route lock status (Locked_Sel meaningful only when Mid_Packet=1)
//   Pkt_Count0, Pkt_Count1         - wrapping count of completed packets per output
module stream_demux_1to2 #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              Clock,
  input  logic              Reset_n,
  input  logic [DATA_W-1:0] In_Data,
  input  logic              In_Valid,
  input  logic              In_Last,
  output logic              In_Ready,
  input  logic              Select_Line,
  output logic [DATA_W-1:0] Out0_Data,
  output logic [DATA_W-1:0] Out1_Data,
  output logic              Out0_Valid,
  output logic              Out1_Valid,
  output logic              Out0_Last,
  output logic              Out1_Last,
  input  logic              Out0_Ready,
  input  logic              Out1_Ready,
  output logic              Mid_Packet,
  output logic              Locked_Sel,
  output logic [CNT_W-1:0]  Pkt_Count0,
  output logic [CNT_W-1:0]  Pkt_Count1
);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e              state_q, state_d;
  logic                locked_sel_q, locked_sel_d;

  logic                out0_vld_q, out0_vld_d;
  logic                out0_last_q, out0_last_d;
  logic [DATA_W-1:0]   out0_dat_q, out0_dat_d;
  logic                out1_vld_q, out1_vld_d;
  logic                out1_last_q, out1_last_d;
  logic [DATA_W-1:0]   out1_dat_q, out1_dat_d;

  logic [CNT_W-1:0]    cnt0_q, cnt0_d;
  logic [CNT_W-1:0]    cnt1_q, cnt1_d;

  logic                route;
  logic                route_vld;
  logic                route_rdy;
  logic                in_rdy;
  logic                accept;
  logic                load0;
  logic                load1;

  // Route and handshake. Only the routed output's state feeds In_Ready, so a
  // stalled unrelated output never blocks the stream.
  always_comb begin
    route     = (state_q == ST_LOCKED) ? locked_sel_q : Select_Line;
    route_vld = route ? out1_vld_q : out0_vld_q;
    route_rdy = route ? Out1_Ready : Out0_Ready;
    in_rdy    = !route_vld || route_rdy;
    accept    = In_Valid && in_rdy;
    load0     = accept && !route;
    load1     = accept &&  route;
  end

  // Output register stages: a load wins over a drain so that drain+load in
  // the same cycle keeps the stage full with the new beat.
  always_comb begin
    out0_vld_d  = out0_vld_q;
    out0_last_d = out0_last_q;
    out0_dat_d  = out0_dat_q;
    if (load0) begin
      out0_vld_d  = 1'b1;
      out0_last_d = In_Last;
      out0_dat_d  = In_Data;
    end else if (out0_vld_q && Out0_Ready) begin
      out0_vld_d  = 1'b0;
    end

    out1_vld_d  = out1_vld_q;
    out1_last_d = out1_last_q;
    out1_dat_d  = out1_dat_q;
    if (load1) begin
      out1_vld_d  = 1'b1;
      out1_last_d = In_Last;
      out1_dat_d  = In_Data;
    end else if (out1_vld_q && Out1_Ready) begin
      out1_vld_d  = 1'b0;
    end
  end

  // Packet counters bump when the Last beat is accepted, not when it drains.
  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (load0 && In_Last) cnt0_d = cnt0_q + CNT_ONE;
    if (load1 && In_Last) cnt1_d = cnt1_q + CNT_ONE;
  end

  // Packet lock FSM. A single-beat packet never leaves IDLE.
  always_comb begin
    state_d      = state_q;
    locked_sel_d = locked_sel_q;
    if (accept) begin
      case (state_q)
        ST_IDLE: begin
          if (!In_Last) begin
            state_d      = ST_LOCKED;
            locked_sel_d = Select_Line;
          end
        end
        ST_LOCKED: begin
          if (In_Last) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      state_q      <= ST_IDLE;
      locked_sel_q <= 1'b0;
      out0_vld_q   <= 1'b0;
      out0_last_q  <= 1'b0;
      out0_dat_q   <= '0;
      out1_vld_q   <= 1'b0;
      out1_last_q  <= 1'b0;
      out1_dat_q   <= '0;
      cnt0_q       <= '0;
      cnt1_q       <= '0;
    end else begin
      state_q      <= state_d;
      locked_sel_q <= locked_sel_d;
      out0_vld_q   <= out0_vld_d;
      out0_last_q  <= out0_last_d;
      out0_dat_q   <= out0_dat_d;
      out1_vld_q   <= out1_vld_d;
      out1_last_q  <= out1_last_d;
      out1_dat_q   <= out1_dat_d;
      cnt0_q       <= cnt0_d;
      cnt1_q       <= cnt1_d;
    end
  end

  assign In_Ready   = in_rdy;
  assign Out0_Data  = out0_dat_q;
  assign Out0_Valid = out0_vld_q;
  assign Out0_Last  = out0_last_q;
  assign Out1_Data  = out1_dat_q;
  assign Out1_Valid = out1_vld_q;
  assign Out1_Last  = out1_last_q;
  assign Mid_Packet = (state_q == ST_LOCKED);
  assign Locked_Sel = locked_sel_q;
  assign Pkt_Count0 = cnt0_q;
  assign Pkt_Count1 = cnt1_q;

endmodule
